// File: rtl/spi_mst_fifo.sv
// spi_mst_fifo: SPI master with TX/RX frame FIFOs, four clock modes, bit order select and back-to-back bursts
module spi_mst_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  parameter int NSS = 8,
  parameter int DIVW = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = (NSS > 1) ? $clog2(NSS) : 1,
  localparam int TW = $clog2(2 * DW + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            cfg_cpol,
  input  logic            cfg_cpha,
  input  logic            cfg_lsbf,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [SW-1:0]   cfg_ss,
  input  logic [DW-1:0]   tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [DW-1:0]   rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            ovf,
  input  logic            ovf_clr,
  output logic            busy,
  output logic            sck,
  output logic            mosi,
  output logic [NSS-1:0]  ss_n,
  input  logic            miso
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;
  state_e          state_q, state_d;
  logic [DIVW-1:0] cnt_q, div_q;
  logic [TW-1:0]   tg_q, tg_n;
  logic            cpha_q, lsbf_q;
  logic [DW-1:0]   sh_q, rsh_q, tx_head;
  logic [DW-1:0]   tx_mem [DEPTH];
  logic [DW-1:0]   rx_mem [DEPTH];
  logic [AW:0]     tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic            tx_empty, tx_full, rx_empty, rx_full, tx_push, rx_pop, rx_wr;
  logic            sck_q, mosi_q, rx_push_q, ovf_q, ovf_d;
  logic [NSS-1:0]  ss_q;
  logic            tick, last, tog, smp, shf, start, burst, load, cph, lsb, drop_ss;

  assign tx_empty = tx_wp_q == tx_rp_q;
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_empty = rx_wp_q == rx_rp_q;
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_wr    = rx_push_q && !rx_full;
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rp_q[AW-1:0]];
  assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
  assign tick     = cnt_q == div_q;
  assign tg_n     = tg_q + TW'(1);
  assign last     = tg_n == TW'(2 * DW);
  assign tog      = (state_q == SHIFT) && tick;
  assign ovf_d    = (rx_push_q && rx_full) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  assign ovf      = ovf_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Next state: each non-idle stage advances on a half-period tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (en && !tx_empty) ? SETUP : IDLE;
      SETUP:   state_d = tick ? SHIFT : SETUP;
      SHIFT:   state_d = (tick && last) ? HOLD : SHIFT;
      HOLD:    state_d = tick ? ((en && !tx_empty) ? SHIFT : GAP) : HOLD;
      GAP:     state_d = tick ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end

  // Decoded controls: frame loads, per-toggle sample/shift and ss release
  always_comb begin
    start   = (state_q == IDLE) && (state_d == SETUP);
    burst   = (state_q == HOLD) && (state_d == SHIFT);
    load    = start || burst;
    drop_ss = (state_q == HOLD) && (state_d == GAP);
    cph     = start ? cfg_cpha : cpha_q;
    lsb     = start ? cfg_lsbf : lsbf_q;
    smp     = tog && (cpha_q ? !tg_n[0] : tg_n[0]);
    shf     = tog && (cpha_q ? tg_n[0] : (!tg_n[0] && !last));
    busy    = state_q != IDLE;
  end

  // Timing counters, config latch, slave select and serial shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= '0;
      tg_q      <= '0;
      cpha_q    <= 1'b0;
      lsbf_q    <= 1'b0;
      sh_q      <= '0;
      rsh_q     <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      rx_push_q <= 1'b0;
      ss_q      <= '1;
    end else begin
      cnt_q     <= (state_q == IDLE || tick) ? '0 : cnt_q + DIVW'(1);
      sck_q     <= (state_q == IDLE) ? cfg_cpol : (tog ? !sck_q : sck_q);
      rx_push_q <= tog && last;
      if (start) begin
        cpha_q <= cfg_cpha;
        lsbf_q <= cfg_lsbf;
        div_q  <= cfg_div;
        ss_q   <= ~(NSS'(1) << cfg_ss);
      end else if (drop_ss) begin
        ss_q <= '1;
      end
      if (load) begin
        tg_q   <= '0;
        mosi_q <= lsb ? tx_head[0] : tx_head[DW-1];
        sh_q   <= cph ? tx_head : (lsb ? tx_head >> 1 : tx_head << 1);
      end else if (tog) begin
        tg_q <= tg_n;
        if (shf) begin
          mosi_q <= lsbf_q ? sh_q[0] : sh_q[DW-1];
          sh_q   <= lsbf_q ? sh_q >> 1 : sh_q << 1;
        end
      end
      if (smp) rsh_q <= lsbf_q ? {miso, rsh_q[DW-1:1]} : {rsh_q[DW-2:0], miso};
    end
  end

  // FIFO pointers and sticky overflow; a full RX FIFO drops the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      tx_wp_q <= tx_wp_q + (AW+1)'(tx_push);
      tx_rp_q <= tx_rp_q + (AW+1)'(load);
      rx_wp_q <= rx_wp_q + (AW+1)'(rx_wr);
      rx_rp_q <= rx_rp_q + (AW+1)'(rx_pop);
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= tx_data;
    if (rx_wr) rx_mem[rx_wp_q[AW-1:0]] <= rsh_q;
  end
endmodule

// File: tb/tb_spi_mst_fifo.sv
// tb_spi_mst_fifo: directed bench with loopback, behavioural SPI slave and RX scoreboard
module tb_spi_mst_fifo;
  logic       clk = 0, rst_n = 1, en = 0;
  logic       cfg_cpol = 0, cfg_cpha = 0, cfg_lsbf = 0;
  logic [7:0] cfg_div = 0;
  logic [2:0] cfg_ss = 0;
  logic [7:0] tx_data = 0;
  logic       tx_valid = 0, rx_ready = 0, ovf_clr = 0, loop = 1;
  logic       tx_ready, rx_valid, ovf, busy, sck, mosi, miso;
  logic [7:0] rx_data, ss_n;
  int         errors = 0, checks = 0, ss_low = 0, leads = 0, ss_fall = 0;
  int         b_low, b_lead, b_fall;
  longint     t_last = 0, t_prev = 0;
  logic [7:0] exp_q [$];
  logic [7:0] sret = 8'h3C, s_rx = 0, s_last = 0;
  logic       s_miso = 0, ss_prev = 1;
  int         s_n = 0;
  logic [7:0] pat [5] = '{8'h96, 8'h5A, 8'hC1, 8'h0F, 8'hB4};

  spi_mst_fifo dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsbf(cfg_lsbf),
    .cfg_div(cfg_div), .cfg_ss(cfg_ss),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy),
    .sck(sck), .mosi(mosi), .ss_n(ss_n), .miso(miso)
  );

  always #5 clk = ~clk;
  assign miso = loop ? mosi : s_miso;

  function automatic logic sbit(input int k);
    return cfg_lsbf ? sret[k] : sret[7-k];
  endfunction

  // Behavioural slave on ss_n[0], plus leading-edge and ss assertion monitors
  always @(sck or ss_n[0]) begin
    if (ss_n[0] !== ss_prev) begin
      ss_prev = ss_n[0];
      if (ss_n[0] === 1'b0) begin
        s_n = 0;
        s_rx = 0;
        s_miso = sbit(0);
        ss_fall++;
      end else s_last = s_rx;
    end else if (ss_n[0] === 1'b0) begin
      if (sck !== cfg_cpol) begin
        leads++;
        t_prev = t_last;
        t_last = $time;
      end
      if ((sck !== cfg_cpol) ^ cfg_cpha) begin
        s_rx = cfg_lsbf ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
        s_n++;
      end else if (s_n < 8) s_miso = sbit(s_n);
    end
  end

  always @(posedge clk) if (ss_n[0] === 1'b0) ss_low <= ss_low + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk("push_ready", tx_ready, 1);
    tx_data = d;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic wait_busy(input logic want, input string tag);
    int n = 0;
    while (busy !== want && n < 3000) begin @(negedge clk); n++; end
    chk(tag, busy, want);
  endtask

  task automatic run_frame(input string tag);
    wait_busy(1, {tag, "_start"});
    wait_busy(0, {tag, "_end"});
  endtask

  task automatic pop_chk(input string tag);
    int n = 0;
    logic [7:0] e = 8'h00;
    while (rx_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, rx_data, e);
    rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    cfg_cpol = 1;
    tick(2);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ss_n", ss_n, 8'hFF);
    chk("rst_mosi", mosi, 0);
    chk("rst_sck", sck, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1;
    tick(1);
    chk("sck_takes_cpol", sck, 1);
    cfg_cpol = 0;
    en = 1;
    cfg_div = 3;
    tick(2);
    b_low = ss_low;
    b_lead = leads;
    push(8'hA5);
    exp_q.push_back(8'hA5);
    run_frame("m0");
    chk("m0_ss_low_clks", ss_low - b_low, 72);
    chk("m0_leads", leads - b_lead, 8);
    chk("m0_sck_period", 32'((t_last - t_prev) / 10), 8);
    pop_chk("m0_rx");
    loop = 0;
    for (int m = 0; m < 5; m++) begin
      cfg_cpol = m[1] | m[2];
      cfg_cpha = m[0] | m[2];
      cfg_lsbf = m[2];
      cfg_div = 8'(m);
      tick(2);
      push(pat[m]);
      exp_q.push_back(8'h3C);
      run_frame($sformatf("slv%0d", m));
      chk($sformatf("slv%0d_mosi", m), s_last, pat[m]);
      pop_chk($sformatf("slv%0d_miso", m));
    end
    cfg_cpol = 0;
    cfg_cpha = 0;
    cfg_lsbf = 0;
    cfg_div = 1;
    loop = 1;
    tick(2);
    cfg_ss = 5;
    push(8'h81);
    exp_q.push_back(8'h81);
    wait_busy(1, "ss5_start");
    tick(2);
    chk("ss5_select", ss_n, 8'hDF);
    wait_busy(0, "ss5_end");
    pop_chk("ss5_rx");
    cfg_ss = 0;
    b_lead = leads;
    b_fall = ss_fall;
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h12 + i * 8'h22));
      exp_q.push_back(8'(8'h12 + i * 8'h22));
    end
    run_frame("burst");
    chk("burst_leads", leads - b_lead, 32);
    chk("burst_ss_falls", ss_fall - b_fall, 1);
    chk("burst_ovf", ovf, 0);
    for (int i = 0; i < 4; i++) pop_chk("burst_rx");
    for (int i = 0; i < 5; i++) begin
      push(8'(8'h21 + i));
      if (i < 4) exp_q.push_back(8'(8'h21 + i));
    end
    run_frame("ovf");
    chk("ovf_set", ovf, 1);
    for (int i = 0; i < 4; i++) pop_chk("ovf_rx");
    chk("ovf_dropped", rx_valid, 0);
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1;
    tick(1);
    ovf_clr = 0;
    chk("ovf_clr", ovf, 0);
    push(8'h66);
    push(8'h99);
    exp_q.push_back(8'h66);
    wait_busy(1, "en_start");
    tick(4);
    en = 0;
    for (int n = 0; n < 3000 && ss_n[0] !== 1'b1; n++) @(negedge clk);
    chk("en_ss_release", ss_n[0], 1);
    chk("en_gap_busy", busy, 1);
    wait_busy(0, "en_end");
    tick(6);
    chk("en_stays_idle", busy, 0);
    pop_chk("en_rx");
    chk("en_single_rx", rx_valid, 0);
    en = 1;
    exp_q.push_back(8'h99);
    run_frame("en_resume");
    pop_chk("en_resume_rx");
    cfg_div = 3;
    push(8'hC3);
    wait_busy(1, "rst_start");
    tick(20);
    rst_n = 0;
    #1;
    chk("rst_mid_ss_n", ss_n, 8'hFF);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rx_valid", rx_valid, 0);
    chk("rst_mid_mosi", mosi, 0);
    tick(2);
    rst_n = 1;
    tick(2);
    chk("rst_no_rx", rx_valid, 0);
    chk("rst_idle", busy, 0);
    push(8'h3A);
    exp_q.push_back(8'h3A);
    run_frame("post_rst");
    pop_chk("post_rst_rx");
    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_mst_fifo.md
SPI_MST_FIFO -- requirements
Module: spi_mst_fifo

Interface
Parameters (name, default, meaning):
- REQ-001 The block SHALL have the parameter DW, default 8, giving the frame width in bits, legal range 4..32.
- REQ-002 The block SHALL have the parameter DEPTH, default 4, giving the TX and RX FIFO depth in frames; it SHALL be a power of 2 and at least 2.
- REQ-003 The block SHALL have the parameter NSS, default 8, giving the number of slave-select lines.
- REQ-004 The block SHALL have the parameter DIVW, default 8, giving the clock-divider field width.

Ports (name, direction, width, meaning):
- REQ-005 clk, in, 1: the single clock; the whole block SHALL be clocked on its rising edge.
- REQ-006 rst_n, in, 1: asynchronous, active-low reset.
- REQ-007 en, in, 1: enables transfers.
- REQ-008 cfg_cpol, cfg_cpha, cfg_lsbf, in, 1 each: clock polarity, clock phase, LSB-first select.
- REQ-009 cfg_div, in, DIVW: SCK half-period equals cfg_div+1 clk cycles.
- REQ-010 cfg_ss, in, clog2(NSS): index of the slave select to drive.
- REQ-011 tx_data, in, DW, with tx_valid, in, 1, and tx_ready, out, 1: the TX push handshake.
- REQ-012 rx_data, out, DW, with rx_valid, out, 1, and rx_ready, in, 1: the RX pop handshake.
- REQ-013 ovf, out, 1: sticky RX overflow flag; ovf_clr, in, 1, clears it.
- REQ-014 busy, out, 1: high when the state is not IDLE.
- REQ-015 sck, out, 1, mosi, out, 1, and ss_n, out, NSS: serial master outputs; miso, in, 1: serial input.

Function
- REQ-016 A push SHALL occur when tx_valid and tx_ready are both high at a clk edge; tx_ready SHALL equal "TX FIFO not full".
- REQ-017 A pop SHALL occur when rx_valid and rx_ready are both high; rx_valid SHALL equal "RX FIFO not empty", and rx_data SHALL show the head entry.
- REQ-018 The state machine SHALL have the states IDLE, SETUP, SHIFT, HOLD and GAP.
- REQ-019 IDLE -> SETUP SHALL occur when en=1 and the TX FIFO is non-empty. On entering SETUP:
  - one TX entry is popped;
  - cfg_* is latched, so later changes take effect only at the next IDLE exit;
  - ss_n[cfg_ss] goes low on the next clk;
  - sck is held at cfg_cpol.
- REQ-020 SETUP SHALL last exactly one half-period, then go to SHIFT.
- REQ-021 SHIFT SHALL produce 2*DW SCK toggles, one toggle per half-period.
  - cpha=0: mosi carries the first bit from SETUP entry; miso is sampled on odd toggles (leading edges); mosi shifts on even toggles except the last.
  - cpha=1: mosi shifts on odd toggles; miso is sampled on even toggles.
- REQ-022 Bit order SHALL be MSB-first when cfg_lsbf=0 and LSB-first when cfg_lsbf=1, for both mosi and the received word.
- REQ-023 On the final toggle, the received word SHALL be pushed to the RX FIFO on the next clk.
- REQ-024 If the RX FIFO is full at that point, the word SHALL be discarded and ovf SHALL be set.
- REQ-025 ovf SHALL clear on ovf_clr=1; when clear and set coincide, set SHALL win.
- REQ-026 SHIFT -> HOLD SHALL occur after the final toggle; HOLD SHALL last one half-period with ss_n still asserted.
- REQ-027 Burst: at the end of HOLD, if en=1 and the TX FIFO is non-empty, the block SHALL pop the next entry and go directly to SHIFT without a SETUP stage; ss_n SHALL stay low and no config re-latch SHALL occur.
- REQ-028 Otherwise, at the end of HOLD the block SHALL deassert all ss_n and go to GAP.
- REQ-029 GAP SHALL last one half-period, then go to IDLE, giving a minimum ss_n-high time of cfg_div+1 clk cycles.
- REQ-030 If en falls during SETUP, SHIFT or HOLD, the current frame SHALL complete and the block SHALL then take the GAP path.
- REQ-031 Simultaneous push and internal pop on the same FIFO SHALL both take effect with the count unchanged; a push to a full FIFO SHALL be ignored (not possible while tx_ready=0).
- REQ-032 The FIFO pointers SHALL be clog2(DEPTH) bits wide, wrap modulo DEPTH, and use an extra bit for full/empty detection.
- REQ-033 The half-period counter SHALL be DIVW bits wide; cfg_div=0 gives sck at clk/2.
- REQ-034 Only ss_n[cfg_ss] SHALL ever be driven low, and at most one ss_n bit SHALL be low at any time.

Reset
- REQ-035 While rst_n=0, and immediately on its assertion (asynchronously), all outputs SHALL take their reset values:
  - state IDLE, FIFOs empty, ovf=0, busy=0;
  - tx_ready=1, rx_valid=0, rx_data=0;
  - ss_n all 1s, mosi=0.
- REQ-036 sck SHALL reset to 0 and take cfg_cpol on the first clk after reset release.
- REQ-037 A reset asserted mid-frame SHALL abort the frame with no RX push, and ss_n SHALL deassert immediately.

Verification
- REQ-038 Mode 0, DW=8, cfg_div=3, push 0xA5, miso looped to mosi:
  - ss_n[0] low for 8*8+4+4 clk;
  - sck period 8 clk;
  - rx_data=0xA5.
- REQ-039 All four cpol/cpha modes plus cfg_lsbf=1 against a behavioural SPI slave returning 0x3C: RX equals 0x3C and the slave sees the pushed byte in each mode.
- REQ-040 Push 4 frames back-to-back: ss_n stays low across all 4 frames with exactly 32 leading edges and a single ss_n assertion.
- REQ-041 Hold rx_ready=0 and send DEPTH+1 frames: the first DEPTH words are retained, ovf=1, and ovf_clr returns it to 0.
- REQ-042 Drop en mid-frame: the frame completes, the queued TX entry remains, and busy falls after GAP.
- REQ-043 Assert rst_n=0 mid-SHIFT: ss_n = all 1s, busy=0, rx_valid=0 in the same cycle, and a later transfer behaves normally.
